// File: rtl/instr_sequencer.sv
// Issuing side of the instruction-register load handshake: walks program memory
// 0..LAST_ADDR and hands each byte over with a four-phase ir_ena/ir_ack exchange.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// DRAIN   | waiting for a stale ir_ack left over from before the run to drop
// FETCH   | capture prog_data into ir_data and raise ir_ena
// ISSUE   | ir_ena/ir_data held until ir_ack rises
// RELEASE | ir_ena low, waiting for ir_ack to fall, then advance or finish
// DONE    | run finished (last address or halt), waiting for start
// ERROR   | ir_ack edge never arrived within TIMEOUT cycles, waiting for start
module instr_sequencer #(
    parameter int ADDR_W    = 4,
    parameter int LAST_ADDR = 15,
    parameter int TIMEOUT   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt_req,
    input  logic [7:0]        prog_data,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [7:0]        ir_data,
    output logic              ir_ena,
    input  logic              ir_ack,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic [ADDR_W:0]   issued
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [ADDR_W-1:0] LAST_C    = ADDR_W'(LAST_ADDR);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        FETCH,
        ISSUE,
        RELEASE,
        DONE,
        ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] prog_addr_q, prog_addr_d;
    logic [7:0]        ir_data_q, ir_data_d;
    logic              ir_ena_q, ir_ena_d;
    logic [ADDR_W:0]   issued_q, issued_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic              cnt_expired;

    assign cnt_inc     = cnt_q + 1'b1;
    assign cnt_expired = (cnt_inc == TIMEOUT_C);

    always_comb begin
        state_d     = state_q;
        prog_addr_d = prog_addr_q;
        ir_data_d   = ir_data_q;
        ir_ena_d    = ir_ena_q;
        issued_d    = issued_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE, DONE, ERROR: begin
                ir_ena_d = 1'b0;
                if (start) begin
                    prog_addr_d = '0;
                    issued_d    = '0;
                    cnt_d       = '0;
                    state_d     = DRAIN;
                end
            end

            DRAIN: begin
                ir_ena_d = 1'b0;
                if (!ir_ack) begin
                    state_d = FETCH;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_expired) begin
                        state_d = ERROR;
                    end
                end
            end

            FETCH: begin
                ir_data_d = prog_data;
                ir_ena_d  = 1'b1;
                cnt_d     = '0;
                state_d   = ISSUE;
            end

            ISSUE: begin
                if (ir_ack) begin
                    ir_ena_d = 1'b0;
                    issued_d = issued_q + 1'b1;
                    cnt_d    = '0;
                    state_d  = RELEASE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_expired) begin
                        ir_ena_d = 1'b0;
                        state_d  = ERROR;
                    end
                end
            end

            RELEASE: begin
                ir_ena_d = 1'b0;
                if (!ir_ack) begin
                    // halt is honoured only here so an in-flight handshake always completes
                    if ((prog_addr_q == LAST_C) || halt_req) begin
                        state_d = DONE;
                    end else begin
                        prog_addr_d = prog_addr_q + 1'b1;
                        state_d     = FETCH;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_expired) begin
                        state_d = ERROR;
                    end
                end
            end

            default: begin
                ir_ena_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            prog_addr_q <= '0;
            ir_data_q   <= 8'h00;
            ir_ena_q    <= 1'b0;
            issued_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            prog_addr_q <= prog_addr_d;
            ir_data_q   <= ir_data_d;
            ir_ena_q    <= ir_ena_d;
            issued_q    <= issued_d;
            cnt_q       <= cnt_d;
        end
    end

    assign prog_addr   = prog_addr_q;
    assign ir_data     = ir_data_q;
    assign ir_ena      = ir_ena_q;
    assign issued      = issued_q;
    assign busy        = (state_q == DRAIN) || (state_q == FETCH) ||
                         (state_q == ISSUE) || (state_q == RELEASE);
    assign done        = (state_q == DONE);
    assign err_timeout = (state_q == ERROR);

endmodule
